reg_file_wb: RTL

- Write-back end of the MIPS datapath.
- Consumes the selected destination register number (rt/rd/$ra) and the write-back source select.
- Captures one write-back beat per cycle in a pending stage, then commits it into a 32x32 register file on the next edge.
- Serves two combinational read ports with read-after-pending bypass, so the decode stage sees the newest value.

---
 rtl/mips_pkg.sv | 14 +
 rtl/reg_file_wb_if.sv | 36 +++
 rtl/reg_file_wb_sel.sv | 24 ++
 rtl/reg_file_wb.sv | 98 +++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS write-back / register file slice.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [1:0] WB_SRC_ALU = 2'b00;
  localparam logic [1:0] WB_SRC_MEM = 2'b01;
  localparam logic [1:0] WB_SRC_PC4 = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_wb_if.sv
// Write-back beat, read ports and status bundle between the pipeline and the register file.
interface reg_file_wb_if
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              wb_valid_i;
  logic              reg_write_i;
  logic [ADDR_W-1:0] write_register_i;
  logic [1:0]        mem_to_reg_i;
  logic [DATA_W-1:0] alu_result_i;
  logic [DATA_W-1:0] mem_data_i;
  logic [DATA_W-1:0] pc_plus4_i;
  logic [ADDR_W-1:0] read_reg1_i;
  logic [ADDR_W-1:0] read_reg2_i;
  logic [DATA_W-1:0] read_data1_o;
  logic [DATA_W-1:0] read_data2_o;
  logic [DATA_W-1:0] wb_data_o;
  logic              wb_pending_o;
  logic [31:0]       commit_count_o;

  modport master (
    output wb_valid_i, reg_write_i, write_register_i, mem_to_reg_i,
           alu_result_i, mem_data_i, pc_plus4_i, read_reg1_i, read_reg2_i,
    input  read_data1_o, read_data2_o, wb_data_o, wb_pending_o, commit_count_o
  );

  modport slave (
    input  wb_valid_i, reg_write_i, write_register_i, mem_to_reg_i,
           alu_result_i, mem_data_i, pc_plus4_i, read_reg1_i, read_reg2_i,
    output read_data1_o, read_data2_o, wb_data_o, wb_pending_o, commit_count_o
  );

endinterface

// File: rtl/reg_file_wb_sel.sv
// Write-back source mux: ALU result, load data or link address; the reserved code falls back to ALU.
module wb_sel
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [1:0]        sel_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] mem_i,
  input  logic [DATA_W-1:0] pc4_i,
  output logic [DATA_W-1:0] data_o
);

  // Pick the write-back source for the pending stage.
  always_comb begin
    data_o = alu_i;
    case (sel_i)
      WB_SRC_MEM: data_o = mem_i;
      WB_SRC_PC4: data_o = pc4_i;
      default:    data_o = alu_i;
    endcase
  end

endmodule

// File: rtl/reg_file_wb.sv
// MIPS write-back end: one-deep pending stage in front of a 32x32 register file,
// with two combinational read ports that bypass from the pending stage.
module reg_file_wb
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREGS  = 2 ** ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_wb_if.slave bus
);

  logic [DATA_W-1:0] regs_q [NREGS];

  logic              pendValid_q, pendValid_d;
  logic [ADDR_W-1:0] pendAddr_q,  pendAddr_d;
  logic [DATA_W-1:0] pendData_q,  pendData_d;
  logic [31:0]       commitCount_q, commitCount_d;

  logic [DATA_W-1:0] selData;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;

  wb_sel #(.DATA_W(DATA_W)) uSel (
    .sel_i  (bus.mem_to_reg_i),
    .alu_i  (bus.alu_result_i),
    .mem_i  (bus.mem_data_i),
    .pc4_i  (bus.pc_plus4_i),
    .data_o (selData)
  );

  // Next state of the pending stage and commit counter; $zero writes never go live.
  always_comb begin
    pendValid_d   = bus.wb_valid_i & bus.reg_write_i &
                    (bus.write_register_i != ADDR_W'(REG_ZERO));
    pendAddr_d    = pendAddr_q;
    pendData_d    = pendData_q;
    commitCount_d = commitCount_q;
    if (bus.wb_valid_i) begin
      pendAddr_d = bus.write_register_i;
      pendData_d = selData;
    end
    if (pendValid_q) begin
      commitCount_d = commitCount_q + 32'd1;
    end
  end

  // Pending stage and counter registers; reset discards any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendValid_q   <= 1'b0;
      pendAddr_q    <= '0;
      pendData_q    <= '0;
      commitCount_q <= '0;
    end else begin
      pendValid_q   <= pendValid_d;
      pendAddr_q    <= pendAddr_d;
      pendData_q    <= pendData_d;
      commitCount_q <= commitCount_d;
    end
  end

  // Register array: commit the pending write one edge after capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (pendValid_q) begin
      regs_q[pendAddr_q] <= pendData_q;
    end
  end

  // Read ports: $zero reads 0, a live pending write to the same register wins, else the array.
  always_comb begin
    readData1 = regs_q[bus.read_reg1_i];
    readData2 = regs_q[bus.read_reg2_i];
    if (bus.read_reg1_i == ADDR_W'(REG_ZERO)) begin
      readData1 = '0;
    end else if (pendValid_q && (bus.read_reg1_i == pendAddr_q)) begin
      readData1 = pendData_q;
    end
    if (bus.read_reg2_i == ADDR_W'(REG_ZERO)) begin
      readData2 = '0;
    end else if (pendValid_q && (bus.read_reg2_i == pendAddr_q)) begin
      readData2 = pendData_q;
    end
  end

  assign bus.read_data1_o   = readData1;
  assign bus.read_data2_o   = readData2;
  assign bus.wb_data_o      = pendData_q;
  assign bus.wb_pending_o   = pendValid_q;
  assign bus.commit_count_o = commitCount_q;

endmodule
